avalon_mm_read_master: RTL
==========================

AVALON_MM_READ_MASTER -- requirements
Module: avalon_mm_read_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: Avalon byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data word width, fixed at 32 for this release.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth and outstanding-read limit, power of two, 2..64.
REQ-004 SHALL have port clk  in  1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_addr in ADDR_W, cmd_len in 16: job command (start byte address, length in words).
REQ-007 SHALL have ports avm_address out ADDR_W, avm_read out 1, avm_byteenable out 4, avm_waitrequest in 1: Avalon-MM read request.
REQ-008 SHALL have ports avm_readdatavalid in 1, avm_readdata in DATA_W, avm_response in 2: Avalon-MM pipelined read response.
REQ-009 SHALL have ports st_valid out 1, st_ready in 1, st_data out DATA_W: output sample stream.
REQ-010 SHALL have ports busy out 1, done out 1, err out 1: status (job active, 1-cycle completion pulse, sticky error).

Function
REQ-011 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-013 SHALL, on acceptance, latch address = {cmd_addr[ADDR_W-1:2], 2'b00}, remaining = cmd_len, clear err, go to ISSUE; cmd_len==0 goes straight to DONE with no bus traffic.
REQ-014 SHALL in ISSUE raise avm_read only when outstanding + fifo_count < FIFO_DEPTH.
REQ-015 SHALL hold avm_read, avm_address stable once raised until a cycle with avm_waitrequest=0 (accept).
REQ-016 SHALL on each accept increment address by 4 (modulo 2^ADDR_W, wrap allowed), decrement remaining, increment outstanding; accept of last word goes to DRAIN.
REQ-017 SHALL drive avm_byteenable = 4'hF whenever avm_read=1; avm_read=0 outside ISSUE.
REQ-018 SHALL push avm_readdata into the FIFO on every avm_readdatavalid while outstanding>0, decrementing outstanding; simultaneous accept and readdatavalid leaves outstanding unchanged.
REQ-019 SHALL set err when avm_readdatavalid arrives with avm_response != 2'b00 (data still pushed) or with outstanding==0 (data dropped).
REQ-020 SHALL leave DRAIN for DONE when outstanding==0 and FIFO empty; DONE asserts done for exactly one cycle then returns to IDLE.
REQ-021 SHALL assert busy in ISSUE, DRAIN, DONE.
REQ-022 SHALL present FIFO head as first-word-fall-through: st_valid = FIFO not empty; st_data stable while st_valid && !st_ready; pop on st_valid && st_ready.
REQ-023 SHALL never overflow the FIFO; simultaneous push and pop on a full FIFO keeps count unchanged.
REQ-024 SHALL have first request latency of 1 cycle: avm_read asserted the cycle after command acceptance.

Reset
REQ-025 SHALL on rst force FSM=IDLE, cmd_ready=1 after release, avm_read=0, avm_address=0, avm_byteenable=0, st_valid=0, st_data=0, busy=0, done=0, err=0, outstanding=0, FIFO empty.
REQ-026 SHALL on reset mid-job abandon the job; responses arriving after release with outstanding==0 are dropped and set err.

Structure
REQ-027 SHALL place FSM state enum, AVM_RESP_OKAY constant and cmd struct in shared package avalon_mm_pkg.
REQ-028 SHALL instantiate one sub-module sync_fifo (parameters WIDTH, DEPTH; count, full, empty outputs).
REQ-029 SHALL size outstanding counter to $clog2(FIFO_DEPTH)+1 bits.

Verification
REQ-030 SHALL cover: cmd_addr=0x1000, len=4, no waitrequest, st_ready=1 -> reads at 0x1000/04/08/0C, 4 words out in order, done pulse once.
REQ-031 SHALL cover: cmd_addr=0x2003, waitrequest high 3 cycles on first read -> avm_address=0x2000 held stable 4 cycles, read accepted once.
REQ-032 SHALL cover: len=20, FIFO_DEPTH=8, st_ready=0 -> exactly 8 reads accepted, avm_read low thereafter; st_ready=1 resumes, all 20 words delivered.
REQ-033 SHALL cover: len=0 -> no avm_read, done pulse 1 cycle after accept, busy high 1 cycle.
REQ-034 SHALL cover: response=2'b10 on word 2 of 3 -> err=1, all 3 words delivered, err cleared on next command accept.
REQ-035 SHALL cover: cmd_addr=0xFFFFFFFC, len=2 -> second read at 0x00000000; rst pulse mid-job -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM read master.
package avalon_mm_pkg;

  // Job controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Avalon-MM response code for a good transfer
  localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

  // Command fields are carried at a fixed maximum width; the top narrows them
  localparam int CMD_ADDR_W = 64;
  localparam int CMD_LEN_W  = 16;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;

  // Clear the byte-offset bits so every request is word aligned
  function automatic logic [CMD_ADDR_W-1:0] word_align(input logic [CMD_ADDR_W-1:0] a);
    return a & ~(CMD_ADDR_W'(3));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
// A push while full is only taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign empty = (count_q == {CW{1'b0}});
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  // Head word is forced to zero when empty so the output is defined after reset
  assign rdata = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/avalon_mm_read_master.sv
// Avalon-MM pipelined read master: fetches cmd_len words starting at cmd_addr
// and streams them out through a FIFO. Requests are throttled so that words in
// flight plus words buffered never exceed FIFO_DEPTH, so the FIFO cannot overflow.
module avalon_mm_read_master
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_len,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic [1:0]        avm_response,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  read_q, read_d;
  logic                  err_q, err_d;

  cmd_t                  cmd_s;
  logic [CMD_ADDR_W-1:0] cmd_aligned_s;
  logic                  unused_cmd_s;
  logic                  cmd_fire_s, accept_s, push_s, pop_s, rsp_err_s;
  logic [CNT_W-1:0]      fifo_count_s, fifo_count_next_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0]     fifo_rdata_s;
  logic [SUM_W-1:0]      inflight_next_s;

  assign cmd_s.addr    = CMD_ADDR_W'(cmd_addr);
  assign cmd_s.len     = cmd_len;
  assign cmd_aligned_s = word_align(cmd_s.addr);
  assign unused_cmd_s  = ^cmd_aligned_s;

  assign cmd_fire_s = cmd_valid && (state_q == ST_IDLE);
  assign accept_s   = read_q && !avm_waitrequest;
  // Responses with nothing outstanding belong to no job and are dropped
  assign push_s     = avm_readdatavalid && (outstanding_q != {CNT_W{1'b0}})
                      && (!fifo_full_s || pop_s);
  assign pop_s      = !fifo_empty_s && st_ready;
  assign rsp_err_s  = avm_readdatavalid
                      && ((avm_response != AVM_RESP_OKAY) || (outstanding_q == {CNT_W{1'b0}}));

  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign avm_read       = read_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = read_q ? 4'hF : 4'h0;
  assign st_valid       = !fifo_empty_s;
  assign st_data        = fifo_rdata_s;

  // Occupancy the FIFO will have next cycle, used to pre-compute read credit
  always_comb begin
    if (push_s && !pop_s) begin
      fifo_count_next_s = fifo_count_s + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      fifo_count_next_s = fifo_count_s - CNT_W'(1);
    end else begin
      fifo_count_next_s = fifo_count_s;
    end
  end

  // Next-state, job bookkeeping and registered request generation
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    err_d         = (cmd_fire_s ? 1'b0 : err_q) | rsp_err_s;

    if (accept_s && !push_s) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (push_s && !accept_s) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end else begin
      outstanding_d = outstanding_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          addr_d      = cmd_aligned_s[ADDR_W-1:0];
          remaining_d = cmd_s.len;
          state_d     = (cmd_s.len == 16'd0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (accept_s) begin
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - 16'd1;
          state_d     = (remaining_q == 16'd1) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == {CNT_W{1'b0}}) && fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Once raised, the request holds: without an accept in-flight+buffered
    // can only shrink, so the credit test below stays true until accepted.
    inflight_next_s = SUM_W'(outstanding_d) + SUM_W'(fifo_count_next_s);
    read_d          = (state_d == ST_ISSUE) && (inflight_next_s < DEPTH_SUM);
  end

  // State and job registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      remaining_q   <= 16'd0;
      outstanding_q <= {CNT_W{1'b0}};
      read_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      read_q        <= read_d;
      err_q         <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (avm_readdata),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule
